// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - Opcode encodings understood by the 8-bit registered ALU.
//   - Sequencer FSM state encoding.
//   - Result substituted for a divide-by-zero command.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_GT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [7:0] DZ_RESULT = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding queued ALU commands.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push       write din this cycle (honoured when not full, or when full
//              and a pop happens in the same cycle)
//   pop        discard the head entry this cycle (ignored when empty)
//   full       DEPTH entries stored
//   empty      no entries stored
//   din        write data
//   dout       head entry, valid whenever !empty (combinational read)
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push, do_pop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer wrapped around the team's registered ALU.
// Buffers (a, b, opcode) commands, issues them to the ALU one at a time,
// captures each result after the ALU's one-cycle latency and presents it
// downstream together with its opcode and a divide-by-zero flag.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         command handshake; in_a, in_b, in_op payload
//   alu_a/alu_b/alu_op        registered operands driven into the ALU
//   alu_result                ALU registered result
//   out_valid/out_ready       result handshake; out_result, out_op, out_err
//   dbg_state                 current FSM state (state_t encoding)
//
// Handshakes: a transfer happens at a posedge where valid && ready are both
// high. The producer keeps payload stable while valid is high and ready low;
// out_valid and all out_* fields hold steady until out_ready is seen.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [2:0]   in_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_op,
  output logic         out_err,
  output logic [1:0]   dbg_state
);

  localparam int DW = 2 * W + 3;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_din, fifo_dout;
  logic [W-1:0]  head_a, head_b;
  logic [2:0]    head_op;
  logic          head_dz;

  state_t       state_q, state_d;
  logic [W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic         dz_q, dz_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_result_q, out_result_d;
  logic [2:0]   out_op_q, out_op_d;
  logic         out_err_q, out_err_d;

  assign fifo_din  = {in_op, in_b, in_a};
  assign fifo_push = in_valid && in_ready;
  assign in_ready  = !fifo_full;

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .din   (fifo_din),
    .dout  (fifo_dout)
  );

  assign head_a  = fifo_dout[W-1:0];
  assign head_b  = fifo_dout[2*W-1:W];
  assign head_op = fifo_dout[2*W+2:2*W];
  assign head_dz = (head_op == OP_DIV) && (head_b == '0);

  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    dz_d         = dz_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_op_d     = out_op_q;
    out_err_d    = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        out_result_d = dz_q ? W'(DZ_RESULT) : alu_result;
        out_op_d     = alu_op_q;
        out_err_d    = dz_q;
        out_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) begin
          // Drop valid in both branches so a consumed result is never
          // presented twice while the next command is in flight.
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_DRIVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any pop loads the ALU operand registers on the same edge. A zero
    // divisor is replaced by 1 so the ALU never produces an undefined value.
    if (fifo_pop) begin
      alu_a_d  = head_a;
      alu_b_d  = head_dz ? W'(1) : head_b;
      alu_op_d = head_op;
      dz_d     = head_dz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      dz_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_op_q     <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      dz_q         <= dz_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_op_q     <= out_op_d;
      out_err_q    <= out_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_op     = out_op_q;
  assign out_err    = out_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer together with a stand-in for the registered ALU.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [2:0]   in_op = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_op;
  logic         out_valid, out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic [2:0]   out_op;
  logic         out_err;
  logic [1:0]   dbg_state;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op), .out_err(out_err),
    .dbg_state(dbg_state)
  );

  // Stand-in for the registered ALU: one cycle from operands to result.
  // A zero divisor yields a junk value, which must never reach the consumer.
  always_ff @(posedge clk) begin
    if (rst) alu_result <= '0;
    else begin
      case (alu_op)
        OP_ADD:  alu_result <= alu_a + alu_b;
        OP_SUB:  alu_result <= alu_a - alu_b;
        OP_MUL:  alu_result <= alu_a * alu_b;
        OP_DIV:  alu_result <= (alu_b == '0) ? 8'hA5 : alu_a / alu_b;
        OP_AND:  alu_result <= alu_a & alu_b;
        OP_OR:   alu_result <= alu_a | alu_b;
        OP_XOR:  alu_result <= alu_a ^ alu_b;
        default: alu_result <= {7'd0, alu_a > alu_b};
      endcase
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic, returns {err, op, result}.
  function automatic logic [11:0] expect_of(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
    int ia, ib, r;
    logic e;
    ia = a; ib = b; e = 1'b0; r = 0;
    case (op)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib;
      3'd2: r = ia * ib;
      3'd3: if (ib == 0) begin r = 255; e = 1'b1; end else r = ia / ib;
      3'd4: r = ia & ib;
      3'd5: r = ia | ib;
      3'd6: r = ia ^ ib;
      default: r = (ia > ib) ? 1 : 0;
    endcase
    return {e, op, r[7:0]};
  endfunction

  // Scoreboard: expectation queued on each accepted command, compared on
  // each consumed result.
  logic [11:0] exp_q[$];
  logic [7:0]  got_q[$];
  int          hs_q[$];

  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (in_valid && in_ready) exp_q.push_back(expect_of(in_a, in_b, in_op));
      if (out_valid && out_ready) begin
        got_q.push_back(out_result);
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got {err,op,res}=0x%0h, required none", {out_err, out_op, out_result});
        end else begin
          check("scoreboard", {20'd0, out_err, out_op, out_result}, {20'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int k;
    logic ok;
    k = 0; ok = 1'b0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: in_ready=%0b, required 1", in_ready);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       err;
  } vec_t;

  // One command into an idle sequencer with out_ready held high.
  task automatic run_single(input vec_t v);
    int acc, k;
    logic seen;
    logic [7:0] drv_b, exp_b;
    exp_b = (v.op == OP_DIV && v.b == 8'd0) ? 8'h01 : v.b;
    out_ready = 1'b1;
    in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc = cyc;
    drv_b = 8'h00; seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (dbg_state == ST_DRIVE) drv_b = alu_b;
      if (out_valid) seen = 1'b1;
    end
    check("latency", cyc - acc, 32'd3);
    check("result", {24'd0, out_result}, {24'd0, v.res});
    check("op", {29'd0, out_op}, {29'd0, v.op});
    check("err", {31'd0, out_err}, {31'd0, v.err});
    check("drive_b", {24'd0, drv_b}, {24'd0, exp_b});
    @(posedge clk); #1;
    @(negedge clk);
    check("valid_cleared", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- test ----------------
  vec_t tbl[11];

  initial begin
    int k;
    logic stable;
    logic [7:0] r0;

    tbl[0]  = '{8'h05, 8'h03, OP_ADD, 8'h08, 1'b0};
    tbl[1]  = '{8'h03, 8'h05, OP_SUB, 8'hFE, 1'b0};
    tbl[2]  = '{8'h10, 8'h10, OP_MUL, 8'h00, 1'b0};
    tbl[3]  = '{8'h80, 8'h7F, OP_GT,  8'h01, 1'b0};
    tbl[4]  = '{8'h07, 8'h00, OP_DIV, 8'hFF, 1'b1};
    tbl[5]  = '{8'h07, 8'h02, OP_DIV, 8'h03, 1'b0};
    tbl[6]  = '{8'hF0, 8'h3C, OP_AND, 8'h30, 1'b0};
    tbl[7]  = '{8'hF0, 8'h0F, OP_OR,  8'hFF, 1'b0};
    tbl[8]  = '{8'hAA, 8'hFF, OP_XOR, 8'h55, 1'b0};
    tbl[9]  = '{8'h7F, 8'h80, OP_GT,  8'h00, 1'b0};
    tbl[10] = '{8'h0D, 8'h07, OP_MUL, 8'h5B, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_alu", {13'd0, alu_op, alu_a, alu_b}, 32'd0);
    check("rst_out", {21'd0, out_op, out_result}, 32'd0);
    @(posedge clk); #1;

    // Table vectors, one at a time
    for (int i = 0; i < 11; i++) run_single(tbl[i]);

    // Back-to-back: SUB, MUL, GT
    out_ready = 1'b1;
    got_q.delete(); hs_q.delete();
    push_cmd(8'h03, 8'h05, OP_SUB);
    push_cmd(8'h10, 8'h10, OP_MUL);
    push_cmd(8'h80, 8'h7F, OP_GT);
    k = 0;
    while (got_q.size() < 3 && k < 50) begin @(negedge clk); k++; end
    check("b2b_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      check("b2b_r0", {24'd0, got_q[0]}, 32'hFE);
      check("b2b_r1", {24'd0, got_q[1]}, 32'h00);
      check("b2b_r2", {24'd0, got_q[2]}, 32'h01);
      check("b2b_gap0", hs_q[1] - hs_q[0], 32'd3);
      check("b2b_gap1", hs_q[2] - hs_q[1], 32'd3);
    end
    @(posedge clk); #1;

    // Stall: consumer blocked, FIFO fills behind the held result
    out_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 5; i++) push_cmd(8'h11 + 8'(i), 8'h00 + 8'(i), OP_ADD);
    k = 0;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    check("stall_full_ready", {31'd0, in_ready}, 32'd0);
    r0 = out_result;
    check("stall_head", {24'd0, r0}, 32'h11);
    stable = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || out_result != r0 || in_ready) stable = 1'b0;
    end
    check("stall_stable", {31'd0, stable}, 32'd1);
    @(posedge clk); #1;
    fork
      push_cmd(8'h30, 8'h05, OP_ADD);
      begin
        @(negedge clk);
        check("full_hold_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    k = 0;
    while (got_q.size() < 6 && k < 100) begin @(negedge clk); k++; end
    check("stall_drained", got_q.size(), 32'd6);
    if (got_q.size() == 6) check("stall_last", {24'd0, got_q[5]}, 32'h35);
    @(posedge clk); #1;

    // Reset during CAPTURE with commands queued
    out_ready = 1'b1;
    push_cmd(8'h21, 8'h01, OP_ADD);
    push_cmd(8'h22, 8'h01, OP_ADD);
    push_cmd(8'h23, 8'h01, OP_ADD);
    k = 0;
    while (dbg_state != ST_CAPTURE && k < 20) begin @(posedge clk); #1; k++; end
    check("capture_reached", {30'd0, dbg_state}, {30'd0, ST_CAPTURE});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out", {21'd0, out_op, out_result}, 32'd0);
    stable = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || dbg_state != ST_IDLE) stable = 1'b0;
    end
    check("mid_rst_flushed", {31'd0, stable}, 32'd1);
    @(posedge clk); #1;
    run_single('{8'h01, 8'h01, OP_ADD, 8'h02, 1'b0});

    // Randomized traffic with a random consumer; many FIFO wraps
    begin
      logic drv_done;
      drv_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 48; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            push_cmd(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                     3'($urandom_range(0, 7)));
          end
          drv_done = 1'b1;
        end
        begin
          int n;
          n = 0;
          while (!(drv_done && exp_q.size() == 0) && n < 3000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            n++;
          end
        end
      join
    end
    check("random_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
